// File: rtl/scalar_divider_if.sv
// Handshake and operand/result bundle for the scalar divider.
// The requester (master) drives start/A/B; the divider (slave) returns
// quotient, remainder, busy/done and the ALU-compatible flag set.
interface scalar_divider_if #(
   parameter int unsigned N = 32
);
   logic         start;
   logic [N-1:0] A;
   logic [N-1:0] B;
   logic [N-1:0] Q;
   logic [N-1:0] Rem;
   logic         busy;
   logic         done;
   logic         N_flag;
   logic         Z_flag;
   logic         C_flag;
   logic         V_flag;

   modport master (
      output start, A, B,
      input  Q, Rem, busy, done, N_flag, Z_flag, C_flag, V_flag
   );

   modport slave (
      input  start, A, B,
      output Q, Rem, busy, done, N_flag, Z_flag, C_flag, V_flag
   );
endinterface

// File: rtl/scalar_divider.sv
// Iterative unsigned restoring divider, one quotient bit per cycle.
// Divide-by-zero resolves in a single cycle with Q=all ones, Rem=A, V=1.
// Result registers and flags only change on the edge entering DONE or on reset.
module scalar_divider #(
   parameter int unsigned N = 32
) (
   input logic           clk,
   input logic           rst,
   scalar_divider_if.slave bus
);

   localparam int unsigned CW = $clog2(N + 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t        state_q;
   logic [N-1:0]  w_q;
   logic [N:0]    p_q;
   logic [N-1:0]  b_q;
   logic [CW-1:0] cnt_q;
   logic [N-1:0]  q_q;
   logic [N-1:0]  rem_q;
   logic          busy_q;
   logic          done_q;
   logic          nf_q;
   logic          zf_q;
   logic          cf_q;
   logic          vf_q;

   logic [N:0]    p_shift;
   logic [N:0]    p_sub;
   logic          ge;
   logic [N:0]    p_d;
   logic [N-1:0]  w_d;

   // One restoring step: shift the next dividend bit into P, subtract B if it fits.
   always_comb begin
      p_shift = {p_q[N-1:0], w_q[N-1]};
      p_sub   = p_shift - {1'b0, b_q};
      ge      = (p_shift >= {1'b0, b_q});
      p_d     = ge ? p_sub : p_shift;
      w_d     = {w_q[N-2:0], ge};
   end

   // Control FSM with registered result, flag and handshake outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         w_q     <= '0;
         p_q     <= '0;
         b_q     <= '0;
         cnt_q   <= '0;
         q_q     <= '0;
         rem_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         nf_q    <= 1'b0;
         zf_q    <= 1'b1;
         cf_q    <= 1'b0;
         vf_q    <= 1'b0;
      end else begin
         unique case (state_q)
            IDLE, DONE: begin
               // DONE shares IDLE's accept logic so back-to-back starts need no idle cycle.
               done_q <= 1'b0;
               busy_q <= 1'b0;
               state_q <= IDLE;
               if (bus.start) begin
                  if (bus.B != '0) begin
                     w_q     <= bus.A;
                     b_q     <= bus.B;
                     p_q     <= '0;
                     cnt_q   <= CW'(N);
                     busy_q  <= 1'b1;
                     state_q <= RUN;
                  end else begin
                     q_q     <= '1;
                     rem_q   <= bus.A;
                     nf_q    <= 1'b1;
                     zf_q    <= 1'b0;
                     cf_q    <= (bus.A != '0);
                     vf_q    <= 1'b1;
                     done_q  <= 1'b1;
                     state_q <= DONE;
                  end
               end
            end
            RUN: begin
               w_q   <= w_d;
               p_q   <= p_d;
               cnt_q <= cnt_q - CW'(1);
               if (cnt_q == CW'(1)) begin
                  q_q     <= w_d;
                  rem_q   <= p_d[N-1:0];
                  nf_q    <= w_d[N-1];
                  zf_q    <= (w_d == '0);
                  cf_q    <= (p_d[N-1:0] != '0);
                  vf_q    <= 1'b0;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                  state_q <= DONE;
               end
            end
            default: begin
               state_q <= IDLE;
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
            end
         endcase
      end
   end

   assign bus.Q      = q_q;
   assign bus.Rem    = rem_q;
   assign bus.busy   = busy_q;
   assign bus.done   = done_q;
   assign bus.N_flag = nf_q;
   assign bus.Z_flag = zf_q;
   assign bus.C_flag = cf_q;
   assign bus.V_flag = vf_q;

endmodule

// File: tb/tb_scalar_divider.sv
// Scoreboard bench for scalar_divider: expected results are queued when an
// operation is started and compared against each observed done pulse.
module tb_scalar_divider;

   localparam int unsigned N = 32;

   typedef struct {
      logic [N-1:0] q;
      logic [N-1:0] rem;
      logic         nf;
      logic         zf;
      logic         cf;
      logic         vf;
      int           cyc;
   } res_t;

   logic clk;
   logic rst;
   int   cyc;
   int   n_tests;
   int   n_fail;
   int   busy_cnt;
   int   excl_viol;

   res_t sb[$];
   res_t obs[$];

   scalar_divider_if #(.N(N)) bus ();

   scalar_divider #(.N(N)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Capture every done pulse plus busy statistics, sampled mid-cycle.
   always @(negedge clk) begin
      res_t r;
      if (bus.busy && bus.done) excl_viol <= excl_viol + 1;
      if (bus.busy) busy_cnt <= busy_cnt + 1;
      if (bus.done) begin
         r.q   = bus.Q;
         r.rem = bus.Rem;
         r.nf  = bus.N_flag;
         r.zf  = bus.Z_flag;
         r.cf  = bus.C_flag;
         r.vf  = bus.V_flag;
         r.cyc = cyc;
         obs.push_back(r);
      end
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic res_t model(input logic [N-1:0] a, input logic [N-1:0] b, input int s);
      res_t e;
      if (b == '0) begin
         e.q   = '1;
         e.rem = a;
         e.nf  = 1'b1;
         e.zf  = 1'b0;
         e.cf  = (a != '0);
         e.vf  = 1'b1;
         e.cyc = s;
      end else begin
         e.q   = a / b;
         e.rem = a % b;
         e.nf  = e.q[N-1];
         e.zf  = (e.q == '0);
         e.cf  = (e.rem != '0);
         e.vf  = 1'b0;
         e.cyc = s + int'(N);
      end
      return e;
   endfunction

   task automatic start_op(input logic [N-1:0] a, input logic [N-1:0] b, output int s);
      @(negedge clk); #1;
      s = cyc + 1;
      bus.start = 1'b1;
      bus.A     = a;
      bus.B     = b;
      sb.push_back(model(a, b, s));
      @(negedge clk); #1;
      bus.start = 1'b0;
      bus.A     = $urandom;
      bus.B     = $urandom;
   endtask

   task automatic wait_result(input string tag, input int max_cyc);
      res_t e;
      res_t o;
      for (int i = 0; i < max_cyc; i++) begin
         if (obs.size() > 0) break;
         @(negedge clk); #1;
      end
      if (obs.size() == 0) begin
         check({tag, "_timeout"}, 64'd1, 64'd0);
         if (sb.size() > 0) void'(sb.pop_front());
      end else if (sb.size() == 0) begin
         void'(obs.pop_front());
         check({tag, "_unexpected_done"}, 64'd1, 64'd0);
      end else begin
         e = sb.pop_front();
         o = obs.pop_front();
         check({tag, "_done_cycle"}, 64'(o.cyc), 64'(e.cyc));
         check({tag, "_Q"},   64'(o.q),   64'(e.q));
         check({tag, "_Rem"}, 64'(o.rem), 64'(e.rem));
         check({tag, "_N"},   64'(o.nf),  64'(e.nf));
         check({tag, "_Z"},   64'(o.zf),  64'(e.zf));
         check({tag, "_C"},   64'(o.cf),  64'(e.cf));
         check({tag, "_V"},   64'(o.vf),  64'(e.vf));
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_Q"},    64'(bus.Q),      64'd0);
      check({tag, "_Rem"},  64'(bus.Rem),    64'd0);
      check({tag, "_busy"}, 64'(bus.busy),   64'd0);
      check({tag, "_done"}, 64'(bus.done),   64'd0);
      check({tag, "_N"},    64'(bus.N_flag), 64'd0);
      check({tag, "_Z"},    64'(bus.Z_flag), 64'd1);
      check({tag, "_C"},    64'(bus.C_flag), 64'd0);
      check({tag, "_V"},    64'(bus.V_flag), 64'd0);
   endtask

   initial begin
      int s;
      int s1;
      int bc0;
      logic [N-1:0] ra;
      logic [N-1:0] rb;

      cyc       = 0;
      n_tests   = 0;
      n_fail    = 0;
      busy_cnt  = 0;
      excl_viol = 0;
      rst       = 1'b1;
      bus.start = 1'b1;
      bus.A     = 32'd5;
      bus.B     = 32'd0;
      repeat (3) @(negedge clk);
      #1;
      check_reset_outputs("reset");
      rst       = 1'b0;
      bus.start = 1'b0;

      // 100 / 7, busy must stay high for exactly N cycles
      bc0 = busy_cnt;
      start_op(32'd100, 32'd7, s);
      wait_result("div_100_7", 40);
      check("busy_cycles_100_7", 64'(busy_cnt - bc0), 64'(N));

      start_op(32'hFFFF_FFFF, 32'd1, s);
      wait_result("div_max_1", 40);

      start_op(32'd3, 32'd10, s);
      wait_result("div_3_10", 40);

      start_op(32'h8000_0000, 32'h8000_0000, s);
      wait_result("div_msb_msb", 40);

      // divide by zero: single-cycle latency, busy never raised
      @(negedge clk); #1;
      bc0 = busy_cnt;
      start_op(32'd5, 32'd0, s);
      wait_result("div_5_0", 5);
      @(negedge clk); #1;
      check("busy_cycles_5_0", 64'(busy_cnt - bc0), 64'd0);

      // start during RUN is ignored; start held through DONE chains a new op
      @(negedge clk); #1;
      s1 = cyc + 1;
      bus.start = 1'b1;
      bus.A     = 32'd24;
      bus.B     = 32'd5;
      sb.push_back(model(32'd24, 32'd5, s1));
      @(negedge clk); #1;
      bus.start = 1'b0;
      while (cyc < s1 + 9) begin
         @(negedge clk); #1;
      end
      bus.start = 1'b1;
      bus.A     = 32'd9;
      bus.B     = 32'd3;
      @(negedge clk); #1;
      bus.start = 1'b0;
      while (cyc < s1 + 20) begin
         @(negedge clk); #1;
      end
      bus.start = 1'b1;
      sb.push_back(model(32'd9, 32'd3, s1 + int'(N) + 1));
      wait_result("b2b_first_24_5", 40);
      @(negedge clk); #1;
      bus.start = 1'b0;
      wait_result("b2b_second_9_3", 40);

      // reset mid-run aborts without a done pulse
      @(negedge clk); #1;
      s = cyc + 1;
      bus.start = 1'b1;
      bus.A     = 32'd1000;
      bus.B     = 32'd3;
      @(negedge clk); #1;
      bus.start = 1'b0;
      while (cyc < s + 14) begin
         @(negedge clk); #1;
      end
      rst = 1'b1;
      @(negedge clk); #1;
      rst = 1'b0;
      check_reset_outputs("midrun_rst");
      repeat (40) @(negedge clk);
      #1;
      check("no_done_after_rst", 64'(obs.size()), 64'd0);
      start_op(32'd1000, 32'd3, s);
      wait_result("div_1000_3_after_rst", 40);

      // randomized operands, including small and zero divisors
      for (int i = 0; i < 12; i++) begin
         ra = $urandom;
         case (i % 4)
            0: rb = 32'($urandom_range(0, 3));
            1: rb = 32'($urandom_range(1, 1000));
            2: rb = ra;
            default: rb = $urandom;
         endcase
         start_op(ra, rb, s);
         wait_result($sformatf("rand%0d", i), 40);
      end

      repeat (5) @(negedge clk);
      #1;
      check("busy_done_overlap", 64'(excl_viol), 64'd0);
      check("leftover_observed", 64'(obs.size()), 64'd0);
      check("leftover_expected", 64'(sb.size()), 64'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL global_timeout: simulation exceeded time limit");
      $fatal(1);
   end

endmodule

// File: doc/scalar_divider.md
# scalar_divider

Iterative unsigned divider for the scalar execute path. It accepts a dividend and a divisor on a start pulse and resolves one quotient bit per cycle by restoring subtraction, which is the inverse of the scalar adder's add path. It returns quotient and remainder with the same N/Z/C/V flag set the scalar ALU exports, so its results can be muxed onto the ALU result and flag lines. It holds the execute stage through a busy/done handshake while it runs.

## Interface
- N, default 32: operand, quotient and remainder width; N ≥ 2.

- clk — in — 1 — single clock; all state updates on the rising edge.
- rst — in — 1 — reset; synchronous, active-high.
- start — in — 1 — request; sampled only when the block is not busy.
- A — in — N — dividend, unsigned; sampled on an accepted start.
- B — in — N — divisor, unsigned; sampled on an accepted start.
- Q — out — N — quotient, registered; holds until the next completion.
- Rem — out — N — remainder, registered; holds until the next completion.
- busy — out — 1 — high while an operation is in flight.
- done — out — 1 — one-cycle pulse; Q, Rem and the flags are valid from this cycle on.
- N_flag — out — 1 — Q[N-1].
- Z_flag — out — 1 — Q is all zeros.
- C_flag — out — 1 — Rem is non-zero (inexact division).
- V_flag — out — 1 — divide by zero.

## Operation
- States:
  - IDLE: waits for start.
  - RUN: iterates.
  - DONE: presents the result and pulses done.
- IDLE, start=1, B≠0:
  - Latch A into the working quotient register W, and latch B.
  - Clear the (N+1)-bit partial remainder P.
  - Load the iteration counter with N.
  - Go to RUN.
- IDLE, start=1, B=0:
  - Go directly to DONE.
  - Result: Q = all ones, Rem = A, V_flag=1, C_flag = (A≠0), N_flag=1, Z_flag=0.
- RUN, each cycle:
  - P' = {P[N-1:0], W[N-1]}.
  - W = W<<1.
  - If P' ≥ {0,B}: P = P' − B and W[0] = 1. Otherwise P = P' and W[0] = 0.
  - Decrement the counter.
  - After the N-th iteration, go to DONE.
- Entering DONE from RUN, registered in the same edge:
  - Q = W, Rem = P[N-1:0].
  - Update the flags; V_flag=0.
- DONE:
  - done=1 and busy=0.
  - Next state is IDLE, or a new operation if start=1 (back-to-back is allowed).
- start while in RUN is ignored; it is not queued.
- A and B may change freely after the accepting edge.
- Outputs Q, Rem and the flags change only on the edge that enters DONE, or on reset.

## Timing
- The start edge is edge 0.
  - B≠0: RUN occupies edges 1..N; done is high in the cycle after edge N. Latency N+1 cycles (33 for N=32).
  - B=0: done is high in the cycle after edge 0. Latency 1 cycle.
- busy is high from the cycle after the accepting edge until the cycle before done, inclusive.
- busy and done are never both high.
- Throughput: one operation every N+1 cycles with start held high continuously.
- Reset values: state=IDLE, Q=0, Rem=0, busy=0, done=0, N_flag=0, Z_flag=1, C_flag=0, V_flag=0.
- rst=1 has priority over start in the same cycle.
- rst asserted mid-RUN:
  - Abort at the next edge and return all outputs to reset values.
  - done is not pulsed.
  - The first start after rst deasserts is accepted normally.

## Test plan
- A=100, B=7, one start pulse:
  - done exactly 33 cycles after the start edge.
  - Q=14, Rem=2, C=1, Z=0, N=0, V=0.
  - busy high for 32 cycles.
- A=0xFFFFFFFF, B=1: Q=0xFFFFFFFF, Rem=0, N=1, C=0, Z=0, V=0.
- A=3, B=10:
  - Q=0, Rem=3, Z=1, C=1.
  - Then A=0x80000000, B=0x80000000: Q=1, Rem=0, Z=0, C=0.
- A=5, B=0:
  - done 1 cycle after start.
  - Q=0xFFFFFFFF, Rem=5, V=1, C=1, N=1; busy never high.
- Start 24/5, then pulse start with 9/3 at cycle 10:
  - The second start is ignored; result Q=4, Rem=4.
  - With start held through the DONE cycle and new operands 9/3, a second operation begins immediately and finishes 33 cycles later with Q=3, Rem=0, Z=0.
- Start 1000/3, assert rst for one cycle at cycle 15:
  - All outputs return to reset values with no done pulse.
  - A new start of 1000/3 completes in 33 cycles with Q=333, Rem=1.
